// File: rtl/fft_capture_sequencer.sv
// Frame-level controller for the FFT input path: writes 2^ADDR_W samples in
// bit-reversed order, hands the buffer to the FFT engine and re-arms the counter.
module fft_capture_sequencer #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              ctr_inc,
    output logic              ctr_clr,
    input  logic [ADDR_W-1:0] ctr_addr,
    input  logic              ctr_full,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              fft_start,
    input  logic              fft_busy,
    input  logic              fft_done,
    output logic [2:0]        state,
    output logic [15:0]       frame_count,
    output logic [15:0]       drop_count,
    output logic              overrun,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CAPTURE   = 3'd1,
        FLUSH     = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t               cur;
    logic [TIMEOUT_W-1:0] watchdog;
    logic [TIMEOUT_W-1:0] wd_next;
    logic                 accept;
    logic                 drop;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign state   = cur;
    assign accept  = (cur == CAPTURE) && enable && sample_valid;
    assign drop    = sample_valid && !accept;
    assign wd_next = watchdog + TIMEOUT_W'(1);

    // Clearing on the last sample leaves the counter at 0 for the next CAPTURE entry.
    always_comb begin
        ctr_inc = 1'b0;
        ctr_clr = 1'b0;
        case (cur)
            IDLE: ctr_clr = 1'b1;
            CAPTURE: begin
                if (!enable)
                    ctr_clr = 1'b1;
                else if (sample_valid) begin
                    if (ctr_full)
                        ctr_clr = 1'b1;
                    else
                        ctr_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= IDLE;
            watchdog    <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fft_start   <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mem_we    <= accept;
            fft_start <= 1'b0;
            if (accept) begin
                mem_addr  <= ctr_addr;
                mem_wdata <= sample_data;
            end
            if (drop) begin
                drop_count <= sat_inc(drop_count);
                overrun    <= 1'b1;
            end
            case (cur)
                IDLE: if (enable) cur <= CAPTURE;
                CAPTURE: begin
                    if (!enable)
                        cur <= IDLE;
                    else if (sample_valid && ctr_full)
                        cur <= FLUSH;
                end
                FLUSH: cur <= START;
                START: begin
                    if (!fft_busy) begin
                        fft_start <= 1'b1;
                        watchdog  <= '0;
                        cur       <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    watchdog <= wd_next;
                    if (fft_done) begin
                        frame_count <= frame_count + 16'd1;
                        cur         <= enable ? CAPTURE : IDLE;
                    end else if (&wd_next) begin
                        timeout_err <= 1'b1;
                        cur         <= IDLE;
                    end
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule
